dram_axi_slave: RTL and testbench
=================================

Name: dram_axi_slave

Overview:
- AXI4-Lite responder with a 64-bit word memory; the target for the DRAM-side bridge master.
- Serves one outstanding transaction at a time: a single read (AR→R) or a single write (AW→W→B).
- Response latency is programmable to stress master handshakes.
- Decodes the fixed DRAM window {6'b100000, idx[7:0], 3'b000}.

Parameters:
- DEPTH, 256, number of 64-bit words; index = ADDR[10:3].
- RD_LAT, 3, idle cycles between AR handshake and R_VALID (0..255).
- WR_LAT, 2, idle cycles between W handshake and B_VALID (0..255).
- BASE_TAG, 6'b100000, required value of ADDR[16:11].

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset
AR_VALID  in  1  read address valid
AR_ADDR  in  17  read byte address
AR_READY  out  1  read address ready
R_VALID  out  1  read data valid
R_DATA  out  64  read data
R_RESP  out  2  2'b00 OKAY, 2'b10 SLVERR
R_READY  in  1  read data ready
AW_VALID  in  1  write address valid
AW_ADDR  in  17  write byte address
AW_READY  out  1  write address ready
W_VALID  in  1  write data valid
W_DATA  in  64  write data
W_READY  out  1  write data ready
B_VALID  out  1  write response valid
B_RESP  out  2  write response
B_READY  in  1  write response ready

Behaviour:
- Clocking and reset: single clock clk; reset rst_n is asynchronous, active-low.
- On reset:
  - State returns to IDLE.
  - All memory words, R_DATA, R_RESP, B_RESP and latency counter clear to 0.
  - All *_READY and *_VALID outputs are 0.
  - Reset mid-transaction abandons it; no partial write is committed.
- One-hot FSM: IDLE, RD_WAIT, RD_RESP, WR_DATA, WR_WAIT, WR_RESP.
- Handshake outputs:
  - AR_READY = IDLE.
  - AW_READY = IDLE && !AR_VALID (read wins a same-cycle AR/AW tie; AW stays pending and must not be dropped).
  - W_READY = WR_DATA.
  - R_VALID = RD_RESP.
  - B_VALID = WR_RESP.
- Address decode, per handshake: legal iff ADDR[16:11]==BASE_TAG, ADDR[2:0]==0, ADDR[10:3] < DEPTH. Index and legal flag are latched at the AR or AW handshake.
- Read path:
  - AR handshake in IDLE at cycle t: latch R_DATA = mem[idx] (0 if illegal) and R_RESP = legal ? 00 : 10.
  - Next state is RD_RESP if RD_LAT==0, else RD_WAIT with counter = RD_LAT-1.
  - RD_WAIT decrements; moves to RD_RESP when counter==0.
  - R_VALID rises at t+1+RD_LAT. R_DATA/R_RESP stay stable while R_VALID && !R_READY.
  - R handshake returns to IDLE; the next AR can be accepted one cycle later.
- Write path:
  - AW handshake latches index and legal flag, then moves to WR_DATA.
  - W handshake at cycle u: if legal, mem[idx] <= W_DATA at edge u; an illegal write modifies nothing. B_RESP = legal ? 00 : 10.
  - Next state is WR_RESP if WR_LAT==0, else WR_WAIT (same counter scheme).
  - B_VALID rises at u+1+WR_LAT, held until B_READY; the B handshake returns to IDLE.
- Ignored inputs:
  - W_VALID outside WR_DATA is ignored (no early W acceptance).
  - AR_VALID/AW_VALID outside IDLE are ignored until IDLE.
- Read-after-write: a read issued after the B handshake returns the new data.
- Outputs in states where they are not valid:
  - R_DATA holds its last value outside RD_RESP.
  - W_DATA is never echoed.
- Illegal state encoding recovers to IDLE.

Test Plan:
- Reset, then AR_ADDR=17'h10000 (idx 0), RD_LAT=3, R_READY=1 → AR_READY=1 at handshake; R_VALID exactly 4 cycles later; R_DATA=0, R_RESP=00.
- AW_ADDR=17'h10008, W_DATA=64'hDEAD_BEEF_0123_4567; then AR of 17'h10008 → B_RESP=00 at 3 cycles after W; read returns DEAD_BEEF_0123_4567.
- AR and AW both valid in IDLE (AR=17'h10010, AW=17'h10018) → AR accepted first, AW_READY=0 that cycle; after R handshake AW accepted; both complete OKAY.
- R_READY held low 5 cycles after R_VALID → R_VALID, R_DATA, R_RESP stable all 5 cycles; single handshake on release.
- Illegal addresses: AW_ADDR=17'h00008 (tag mismatch) write, then AR 17'h10004 (misaligned) → B_RESP=10, R_RESP=10, R_DATA=0; a read of 17'h10008 shows prior data unchanged.
- Assert rst_n low during WR_WAIT after W to idx 5 → outputs drop to 0 immediately; after release a read of idx 5 returns 0; FSM is IDLE with AR_READY=1.

Source files
------------

// File: rtl/dram_axi_slave.sv
// AXI4-Lite responder backed by a 64-bit word memory at the fixed DRAM window.
// Latency: R_VALID at RD_LAT+1 cycles after AR, B_VALID at WR_LAT+1 cycles after W.
// Backpressure: one transaction in flight; R/B held stable until R_READY/B_READY.
module dram_axi_slave #(
  parameter int          DEPTH    = 256,
  parameter int          RD_LAT   = 3,
  parameter int          WR_LAT   = 2,
  parameter logic [5:0]  BASE_TAG = 6'b100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        AR_VALID,
  input  logic [16:0] AR_ADDR,
  output logic        AR_READY,
  output logic        R_VALID,
  output logic [63:0] R_DATA,
  output logic [1:0]  R_RESP,
  input  logic        R_READY,
  input  logic        AW_VALID,
  input  logic [16:0] AW_ADDR,
  output logic        AW_READY,
  input  logic        W_VALID,
  input  logic [63:0] W_DATA,
  output logic        W_READY,
  output logic        B_VALID,
  output logic [1:0]  B_RESP,
  input  logic        B_READY
);

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [1:0] OKAY    = 2'b00;
  localparam logic [1:0] SLVERR  = 2'b10;

  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    RD_WAIT = 6'b000010,
    RD_RESP = 6'b000100,
    WR_DATA = 6'b001000,
    WR_WAIT = 6'b010000,
    WR_RESP = 6'b100000
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  wr_idx;
  logic        wr_legal;
  logic [63:0] mem [DEPTH];

  // Window match, word alignment and in-range index.
  function automatic logic addr_ok(input logic [16:0] a);
    return (a[16:11] == BASE_TAG) && (a[2:0] == 3'b000) && ({1'b0, a[10:3]} < DEPTH_W);
  endfunction

  logic       ar_ok;
  logic       aw_ok;
  logic [7:0] ar_idx;
  logic       w_hs;

  assign ar_ok  = addr_ok(AR_ADDR);
  assign aw_ok  = addr_ok(AW_ADDR);
  assign ar_idx = AR_ADDR[10:3];
  assign w_hs   = (state == WR_DATA) && W_VALID;

  // Ready/valid decode straight from the state register; AR wins a same-cycle tie
  // with AW. Readies are forced low while reset is asserted.
  assign AR_READY = rst_n && (state == IDLE);
  assign AW_READY = rst_n && (state == IDLE) && !AR_VALID;
  assign W_READY  = (state == WR_DATA);
  assign R_VALID  = (state == RD_RESP);
  assign B_VALID  = (state == WR_RESP);

  // Transaction FSM: address capture, latency countdown and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_idx   <= '0;
      wr_legal <= 1'b0;
      R_DATA   <= '0;
      R_RESP   <= OKAY;
      B_RESP   <= OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (AR_VALID) begin
            R_DATA <= ar_ok ? mem[ar_idx] : '0;
            R_RESP <= ar_ok ? OKAY : SLVERR;
            if (RD_LAT == 0) begin
              state <= RD_RESP;
            end else begin
              state <= RD_WAIT;
              cnt   <= 8'(RD_LAT - 1);
            end
          end else if (AW_VALID) begin
            wr_idx   <= AW_ADDR[10:3];
            wr_legal <= aw_ok;
            state    <= WR_DATA;
          end
        end
        RD_WAIT: begin
          if (cnt == 8'd0) state <= RD_RESP;
          else             cnt   <= cnt - 8'd1;
        end
        RD_RESP: begin
          if (R_READY) state <= IDLE;
        end
        WR_DATA: begin
          if (W_VALID) begin
            B_RESP <= wr_legal ? OKAY : SLVERR;
            if (WR_LAT == 0) begin
              state <= WR_RESP;
            end else begin
              state <= WR_WAIT;
              cnt   <= 8'(WR_LAT - 1);
            end
          end
        end
        WR_WAIT: begin
          if (cnt == 8'd0) state <= WR_RESP;
          else             cnt   <= cnt - 8'd1;
        end
        WR_RESP: begin
          if (B_READY) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Word storage: cleared by reset, committed only on a legal W handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (w_hs && wr_legal) begin
      mem[wr_idx] <= W_DATA;
    end
  end

endmodule

// File: tb/tb_dram_axi_slave.sv
// Scoreboard bench for dram_axi_slave: expectations queued at address/data
// handshake from a reference memory model, popped when R or B is delivered.
module tb_dram_axi_slave;

  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;
  localparam int BUDGET = 64;

  logic        clk;
  logic        rst_n;
  logic        AR_VALID;
  logic [16:0] AR_ADDR;
  logic        AR_READY;
  logic        R_VALID;
  logic [63:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_READY;
  logic        AW_VALID;
  logic [16:0] AW_ADDR;
  logic        AW_READY;
  logic        W_VALID;
  logic [63:0] W_DATA;
  logic        W_READY;
  logic        B_VALID;
  logic [1:0]  B_RESP;
  logic        B_READY;

  dram_axi_slave #(
    .DEPTH(256), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .BASE_TAG(6'b100000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
    .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
    .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
    .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dat;
    logic [1:0]  resp;
  } rexp_t;

  rexp_t       rd_q[$];
  logic [1:0]  b_q[$];
  logic [63:0] model [256];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic f_legal(input logic [16:0] a);
    return (a[16:11] == 6'b100000) && (a[2:0] == 3'b000);
  endfunction

  // Read with R_READY held low for 'hold' cycles once R_VALID is up.
  task automatic rd(input logic [16:0] addr, input int hold);
    int    n;
    rexp_t e;
    AR_VALID = 1'b1;
    AR_ADDR  = addr;
    R_READY  = (hold == 0);
    #1;
    n = 0;
    while (!AR_READY && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("ar_wait", 64'(n < BUDGET), 64'd1);
    chk("aw_rdy_tie", 64'(AW_READY), 64'd0);
    e.dat  = f_legal(addr) ? model[addr[10:3]] : 64'd0;
    e.resp = f_legal(addr) ? 2'b00 : 2'b10;
    rd_q.push_back(e);
    @(negedge clk); #1;
    AR_VALID = 1'b0;
    n = 1;
    while (!R_VALID && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("r_lat", 64'(n), 64'(RD_LAT + 1));
    for (int i = 0; i < hold; i++) begin
      chk("r_hold_vld", 64'(R_VALID), 64'd1);
      chk("r_hold_dat", R_DATA, rd_q[0].dat);
      chk("r_hold_resp", 64'(R_RESP), 64'(rd_q[0].resp));
      @(negedge clk); #1;
    end
    R_READY = 1'b1;
    e = rd_q.pop_front();
    chk("r_data", R_DATA, e.dat);
    chk("r_resp", 64'(R_RESP), 64'(e.resp));
    @(negedge clk); #1;
    R_READY = 1'b0;
    chk("r_single", 64'(R_VALID), 64'd0);
  endtask

  // Write; with rst_mid the reset is pulsed while the response is still pending.
  task automatic wr(input logic [16:0] addr, input logic [63:0] data, input bit rst_mid);
    int         n;
    logic [1:0] eb;
    AW_VALID = 1'b1;
    AW_ADDR  = addr;
    W_VALID  = 1'b0;
    #1;
    n = 0;
    while (!AW_READY && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("aw_wait", 64'(n < BUDGET), 64'd1);
    chk("w_rdy_early", 64'(W_READY), 64'd0);
    @(negedge clk); #1;
    AW_VALID = 1'b0;
    W_VALID  = 1'b1;
    W_DATA   = data;
    #1;
    n = 0;
    while (!W_READY && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("w_wait", 64'(n < BUDGET), 64'd1);
    if (f_legal(addr)) model[addr[10:3]] = data;
    b_q.push_back(f_legal(addr) ? 2'b00 : 2'b10);
    @(negedge clk); #1;
    W_VALID = 1'b0;
    if (rst_mid) begin
      rst_n = 1'b0;
      #1;
      chk("rst_ar_rdy", 64'(AR_READY), 64'd0);
      chk("rst_aw_rdy", 64'(AW_READY), 64'd0);
      chk("rst_w_rdy", 64'(W_READY), 64'd0);
      chk("rst_b_vld", 64'(B_VALID), 64'd0);
      chk("rst_r_vld", 64'(R_VALID), 64'd0);
      chk("rst_b_resp", 64'(B_RESP), 64'd0);
      chk("rst_r_data", R_DATA, 64'd0);
      for (int i = 0; i < 256; i++) model[i] = 64'd0;
      b_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_idle_ar_rdy", 64'(AR_READY), 64'd1);
      return;
    end
    n = 1;
    while (!B_VALID && n < BUDGET) begin @(negedge clk); #1; n++; end
    chk("b_lat", 64'(n), 64'(WR_LAT + 1));
    B_READY = 1'b1;
    eb = b_q.pop_front();
    chk("b_resp", 64'(B_RESP), 64'(eb));
    @(negedge clk); #1;
    B_READY = 1'b0;
    chk("b_single", 64'(B_VALID), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16:0] a;
    logic [63:0] d;
    for (int i = 0; i < 256; i++) model[i] = 64'd0;
    rst_n = 1'b0;
    AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
    AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ar_rdy", 64'(AR_READY), 64'd0);
    chk("reset_aw_rdy", 64'(AW_READY), 64'd0);
    chk("reset_r_vld", 64'(R_VALID), 64'd0);
    chk("reset_b_vld", 64'(B_VALID), 64'd0);
    chk("reset_r_data", R_DATA, 64'd0);
    chk("reset_r_resp", 64'(R_RESP), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_ar_rdy", 64'(AR_READY), 64'd1);

    // Read of idx 0 straight after reset.
    rd(17'h10000, 0);
    // Write then read back idx 1.
    wr(17'h10008, 64'hDEAD_BEEF_0123_4567, 1'b0);
    rd(17'h10008, 0);
    // Same-cycle AR/AW: read first, pending AW accepted afterwards.
    AW_VALID = 1'b1;
    AW_ADDR  = 17'h10018;
    rd(17'h10010, 0);
    wr(17'h10018, 64'h0BAD_F00D_CAFE_0001, 1'b0);
    rd(17'h10018, 0);
    // Read response backpressured for 5 cycles.
    rd(17'h10008, 5);
    // Illegal tag write, misaligned read, then original data intact.
    wr(17'h00008, 64'h5555_AAAA_5555_AAAA, 1'b0);
    rd(17'h10004, 0);
    rd(17'h10008, 0);
    // A few random legal write/read pairs.
    for (int k = 0; k < 4; k++) begin
      a = {6'b100000, 8'($urandom_range(16, 255)), 3'b000};
      d = {$urandom, $urandom};
      wr(a, d, 1'b0);
      rd(a, k);
    end
    // Reset while the write to idx 5 waits for its response.
    wr(17'h10028, 64'h1234_5678_9ABC_DEF0, 1'b1);
    rd(17'h10028, 0);
    rd(17'h10008, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
